// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM command link: drive codes, frame timing
// defaults and decoder state encoding.
package pwm_pkg;

  // Drive command codes, shared with the generator side
  localparam logic [1:0] DRIVE = 2'b10;
  localparam logic [1:0] STOP  = 2'b00;
  localparam logic [1:0] BACK  = 2'b01;

  // Frame timing defaults in clk_dec ticks
  localparam int PERIOD_DEF  = 40;
  localparam int W_BACK_DEF  = 2;
  localparam int W_STOP_DEF  = 3;
  localparam int W_DRIVE_DEF = 4;
  localparam int TIMEOUT_DEF = 80;
  localparam int CW_DEF      = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } dec_state_e;

  // Result of classifying a measured high width
  typedef struct packed {
    logic       ok;
    logic [1:0] code;
  } width_dec_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for an asynchronous input followed by a registered
// edge detector. Edge pulses are aligned with the cycle in which pwm_s first
// shows the new level. Edges are suppressed until the synchronizer has been
// refilled after reset, so a level already present at reset release is not
// mistaken for an edge.
module pwm_sync_edge (
  input  logic clk_dec,
  input  logic rst,
  input  logic din,
  output logic pwm_s,
  output logic rise,
  output logic fall
);

  logic sync_p0;
  logic sync_p1;
  logic vld_p0;
  logic vld_p1;
  logic vld_p2;

  // Synchronize, keep a registered copy, and emit one-cycle edge pulses
  always_ff @(posedge clk_dec) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      pwm_s   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      pwm_s   <= sync_p1;
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
      vld_p2  <= vld_p1;
      rise    <= vld_p2 & sync_p1 & ~pwm_s;
      fall    <= vld_p2 & ~sync_p1 & pwm_s;
    end
  end

endmodule

// File: rtl/pwm_decode.sv
// Servo-style PWM frame decoder: measures the high width and rise-to-rise
// period of pwm_in and recovers the 2-bit drive command, flagging width,
// period and link-loss errors. Loss of the link forces a failsafe stop.
module pwm_decode
  import pwm_pkg::*;
#(
  parameter int PERIOD  = PERIOD_DEF,
  parameter int W_BACK  = W_BACK_DEF,
  parameter int W_STOP  = W_STOP_DEF,
  parameter int W_DRIVE = W_DRIVE_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CW      = CW_DEF
) (
  input  logic       clk_dec,
  input  logic       rst,
  input  logic       pwm_in,
  output logic [1:0] drive,
  output logic       valid,
  output logic       cmd_stb,
  output logic       err_stb
);

  localparam logic [CW-1:0] PERIOD_C = CW'(PERIOD);
  localparam logic [CW-1:0] WB_C     = CW'(W_BACK);
  localparam logic [CW-1:0] WS_C     = CW'(W_STOP);
  localparam logic [CW-1:0] WD_C     = CW'(W_DRIVE);
  localparam logic [CW-1:0] TO_C     = CW'(TIMEOUT);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  logic          pwm_s;
  logic          rise;
  logic          fall;
  logic [CW-1:0] hcnt;
  logic [CW-1:0] pcnt;
  logic          timeout;

  dec_state_e    state_q;
  dec_state_e    state_d;
  logic          first_q;
  logic          first_d;

  width_dec_t    wdec;
  logic [1:0]    drive_d;
  logic          valid_d;
  logic          cmd_d;
  logic          err_d;

  // Counter increment that sticks at the timeout value instead of wrapping
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v >= TO_C) return TO_C;
    return v + ONE_C;
  endfunction

  // Map a measured high width onto a drive code, or reject it
  function automatic width_dec_t classify(input logic [CW-1:0] w);
    width_dec_t r;
    r.ok   = 1'b1;
    r.code = STOP;
    if (w == WB_C)      r.code = BACK;
    else if (w == WS_C) r.code = STOP;
    else if (w == WD_C) r.code = DRIVE;
    else                r.ok   = 1'b0;
    return r;
  endfunction

  pwm_sync_edge u_sync (
    .clk_dec (clk_dec),
    .rst     (rst),
    .din     (pwm_in),
    .pwm_s   (pwm_s),
    .rise    (rise),
    .fall    (fall)
  );

  // A rise arriving in the same cycle as the timeout wins over the timeout
  assign timeout = (state_q != IDLE) && !rise && (pcnt == TO_C);

  // High-width and rise-to-rise counters, both restarting at 1 on a rise
  always_ff @(posedge clk_dec) begin
    if (rst) begin
      hcnt <= '0;
      pcnt <= '0;
    end else begin
      if (rise)       hcnt <= ONE_C;
      else if (pwm_s) hcnt <= sat_inc(hcnt);
      if (rise) pcnt <= ONE_C;
      else      pcnt <= sat_inc(pcnt);
    end
  end

  // State register and first-frame flag
  always_ff @(posedge clk_dec) begin
    if (rst) begin
      state_q <= IDLE;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
    end
  end

  // Next state: track the pulse phase, drop to IDLE when the link goes quiet
  always_comb begin
    state_d = state_q;
    first_d = first_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
          first_d = 1'b1;
        end
      end
      HIGH: begin
        if (timeout)   state_d = IDLE;
        else if (fall) state_d = LOW;
      end
      LOW: begin
        if (timeout) begin
          state_d = IDLE;
        end else if (rise) begin
          state_d = HIGH;
          first_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decisions: decode on fall, check period on rise, failsafe on loss
  always_comb begin
    wdec    = classify(hcnt);
    drive_d = drive;
    valid_d = valid;
    cmd_d   = 1'b0;
    err_d   = 1'b0;
    if (timeout) begin
      drive_d = STOP;
      valid_d = 1'b0;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        HIGH: begin
          if (fall) begin
            if (wdec.ok) begin
              drive_d = wdec.code;
              valid_d = 1'b1;
              cmd_d   = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        LOW: begin
          if (rise && !first_q && (pcnt != PERIOD_C)) begin
            valid_d = 1'b0;
            err_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output registers
  always_ff @(posedge clk_dec) begin
    if (rst) begin
      drive   <= STOP;
      valid   <= 1'b0;
      cmd_stb <= 1'b0;
      err_stb <= 1'b0;
    end else begin
      drive   <= drive_d;
      valid   <= valid_d;
      cmd_stb <= cmd_d;
      err_stb <= err_d;
    end
  end

endmodule

// File: tb/tb_pwm_decode.sv
// Bench for pwm_decode: directed frame sequences plus randomized frames,
// checked every cycle against a sample-index model of the frame rules.
module tb_pwm_decode;
  import pwm_pkg::*;

  localparam int PERIOD  = 40;
  localparam int TIMEOUT = 80;
  localparam int LAT     = 3;

  logic       clk_dec = 1'b0;
  logic       rst     = 1'b1;
  logic       pwm_in  = 1'b0;
  logic [1:0] drive;
  logic       valid;
  logic       cmd_stb;
  logic       err_stb;

  int total   = 0;
  int bad     = 0;
  int mon_cmd = 0;
  int mon_err = 0;

  typedef struct packed {
    logic [1:0] drv;
    logic       vld;
    logic       cmd;
    logic       err;
  } obs_t;

  always #5 clk_dec = ~clk_dec;

  pwm_decode dut (
    .clk_dec (clk_dec),
    .rst     (rst),
    .pwm_in  (pwm_in),
    .drive   (drive),
    .valid   (valid),
    .cmd_stb (cmd_stb),
    .err_stb (err_stb)
  );

  // ---------------- reference model ----------------
  // Works on the sequence of pwm_in samples taken at each clock edge.
  // Events are judged from sample indices; the result of sample n is what
  // the outputs must show after edge n+LAT.
  obs_t       pipe [LAT];
  obs_t       expv;
  bit         started  = 0;
  int         m_n      = 0;
  bit         m_have   = 0;
  bit         m_prev   = 0;
  bit         m_track  = 0;
  bit         m_first  = 0;
  bit         m_inhigh = 0;
  int         m_lr     = 0;
  logic [1:0] m_drive  = 2'b00;
  bit         m_valid  = 0;

  always @(posedge clk_dec) begin : model
    obs_t nw;
    bit   x;
    bit   rs;
    bit   fl;
    int   w;
    x = pwm_in;
    if (rst) begin
      started = 1;
      expv    = '0;
      for (int i = 0; i < LAT; i++) pipe[i] = '0;
      m_have  = 0;
      m_track = 0;
      m_drive = 2'b00;
      m_valid = 0;
    end else begin
      expv = pipe[0];
      for (int i = 0; i < LAT - 1; i++) pipe[i] = pipe[i+1];
      nw = '0;
      if (!m_have) begin
        m_have = 1;
      end else begin
        rs = x && !m_prev;
        fl = !x && m_prev;
        if (m_track && !rs && (m_n - m_lr) == TIMEOUT) begin
          m_track = 0;
          m_drive = 2'b00;
          m_valid = 0;
          nw.err  = 1;
        end else if (rs) begin
          if (m_track && !m_first && (m_n - m_lr) != PERIOD) begin
            nw.err  = 1;
            m_valid = 0;
          end
          m_first  = !m_track;
          m_track  = 1;
          m_inhigh = 1;
          m_lr     = m_n;
        end else if (fl && m_track && m_inhigh) begin
          m_inhigh = 0;
          w = m_n - m_lr;
          if (w == 2 || w == 3 || w == 4) begin
            m_drive = (w == 2) ? 2'b01 : (w == 3) ? 2'b00 : 2'b10;
            m_valid = 1;
            nw.cmd  = 1;
          end else begin
            nw.err = 1;
          end
        end
      end
      m_prev     = x;
      nw.drv     = m_drive;
      nw.vld     = m_valid;
      pipe[LAT-1] = nw;
    end
    m_n++;
  end

  // Per-cycle comparison of the DUT against the model
  always @(negedge clk_dec) begin
    if (started) begin
      total++;
      if ({drive, valid, cmd_stb, err_stb} !== {expv.drv, expv.vld, expv.cmd, expv.err}) begin
        bad++;
        $display("FAIL model @%0t: got drive=%b valid=%b cmd=%b err=%b, want drive=%b valid=%b cmd=%b err=%b",
                 $time, drive, valid, cmd_stb, err_stb, expv.drv, expv.vld, expv.cmd, expv.err);
      end
    end
  end

  // Strobe counters used by the literal checks
  always @(posedge clk_dec) begin
    #1;
    if (cmd_stb === 1'b1) mon_cmd++;
    if (err_stb === 1'b1) mon_err++;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // One frame of p ticks with w ticks high; optional one-tick reset at rst_at
  task automatic frame(input int w, input int p, input int rst_at);
    for (int t = 0; t < p; t++) begin
      pwm_in = (t < w);
      rst    = (t == rst_at);
      @(negedge clk_dec);
      if (t == rst_at) begin
        check("rst_mid_drive", int'(drive), 0);
        check("rst_mid_valid", int'(valid), 0);
        check("rst_mid_cmd", int'(cmd_stb), 0);
        check("rst_mid_err", int'(err_stb), 0);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    int c0;
    int e0;

    // Reset
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk_dec);
    check("reset_drive", int'(drive), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_cmd", int'(cmd_stb), 0);
    check("reset_err", int'(err_stb), 0);
    check("reset_state", int'(dut.state_q), int'(IDLE));
    rst = 1'b0;
    repeat (6) @(negedge clk_dec);

    // First drive frame with latency probe around the fall
    c0 = mon_cmd;
    e0 = mon_err;
    pwm_in = 1'b1;
    repeat (4) @(negedge clk_dec);
    pwm_in = 1'b0;
    repeat (3) @(negedge clk_dec);
    check("lat_k2_cmd", int'(cmd_stb), 0);
    @(negedge clk_dec);
    check("lat_k3_cmd", int'(cmd_stb), 1);
    check("lat_k3_drive", int'(drive), 2);
    check("lat_k3_valid", int'(valid), 1);
    repeat (PERIOD - 4 - 4) @(negedge clk_dec);
    repeat (4) frame(4, PERIOD, -1);
    check("drive_cmd_count", mon_cmd - c0, 5);
    check("drive_err_count", mon_err - e0, 0);

    // Back then stop
    c0 = mon_cmd;
    e0 = mon_err;
    repeat (3) frame(2, PERIOD, -1);
    check("back_drive", int'(drive), 1);
    repeat (3) frame(3, PERIOD, -1);
    check("stop_drive", int'(drive), 0);
    check("bs_cmd_count", mon_cmd - c0, 6);
    check("bs_err_count", mon_err - e0, 0);

    // Bad width while driving
    repeat (2) frame(4, PERIOD, -1);
    e0 = mon_err;
    c0 = mon_cmd;
    frame(5, PERIOD, -1);
    check("badw_err", mon_err - e0, 1);
    check("badw_cmd", mon_cmd - c0, 0);
    check("badw_drive", int'(drive), 2);
    check("badw_valid", int'(valid), 1);
    c0 = mon_cmd;
    frame(4, PERIOD, -1);
    check("badw_next_cmd", mon_cmd - c0, 1);

    // Short period
    e0 = mon_err;
    frame(4, PERIOD - 2, -1);
    frame(4, PERIOD, -1);
    check("per_err", mon_err - e0, 1);
    check("per_valid_back", int'(valid), 1);

    // Stuck low
    frame(4, PERIOD, -1);
    e0 = mon_err;
    frame(4, 130, -1);
    check("lo_err", mon_err - e0, 1);
    check("lo_drive", int'(drive), 0);
    check("lo_valid", int'(valid), 0);
    check("lo_state", int'(dut.state_q), int'(IDLE));
    e0 = mon_err;
    repeat (2) frame(4, PERIOD, -1);
    check("lo_rec_err", mon_err - e0, 0);
    check("lo_rec_drive", int'(drive), 2);
    check("lo_rec_valid", int'(valid), 1);

    // Stuck high
    e0 = mon_err;
    frame(130, 130, -1);
    check("hi_err", mon_err - e0, 1);
    check("hi_drive", int'(drive), 0);
    check("hi_valid", int'(valid), 0);
    check("hi_state", int'(dut.state_q), int'(IDLE));
    frame(0, 20, -1);
    e0 = mon_err;
    repeat (2) frame(4, PERIOD, -1);
    check("hi_rec_err", mon_err - e0, 0);
    check("hi_rec_valid", int'(valid), 1);

    // Reset during a high pulse
    c0 = mon_cmd;
    e0 = mon_err;
    frame(4, PERIOD, 2);
    check("rstp_cmd", mon_cmd - c0, 0);
    check("rstp_err", mon_err - e0, 0);
    c0 = mon_cmd;
    repeat (2) frame(4, PERIOD, -1);
    check("rstp_next_cmd", mon_cmd - c0, 2);
    check("rstp_next_drive", int'(drive), 2);
    check("rstp_next_valid", int'(valid), 1);

    // Randomized frames
    for (int i = 0; i < 150; i++) begin
      int r;
      int w;
      int p;
      int ra;
      r  = int'($urandom_range(0, 15));
      p  = PERIOD;
      ra = -1;
      w  = 4;
      if ($urandom_range(0, 7) == 0) p = int'($urandom_range(30, 50));
      if (r < 4)       w = 2;
      else if (r < 8)  w = 3;
      else if (r < 12) w = 4;
      else if (r == 12) w = int'($urandom_range(0, 7));
      else if (r == 13) begin
        w = int'($urandom_range(1, 4));
        p = int'($urandom_range(85, 110));
      end else if (r == 14) begin
        p = int'($urandom_range(85, 100));
        w = p;
      end else begin
        ra = int'($urandom_range(0, 39));
      end
      frame(w, p, ra);
    end

    pwm_in = 1'b0;
    repeat (10) @(negedge clk_dec);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_decode.md
Name: pwm_decode

Overview:
- Receive-side counterpart of the motor PWM generator: measures a servo-style PWM frame on `pwm_in` and recovers the 2-bit drive command (back/stop/drive).
- Used on the vehicle side to recover commands from a PWM link, and in loopback against the generator for self-test.
- Frame: PERIOD ticks of `clk_dec`; high width 2/3/4 ticks selects back/stop/drive.

Parameters:
- PERIOD, 40, frame length in `clk_dec` ticks, measured rise to rise.
- W_BACK, 2, high width in ticks that encodes back.
- W_STOP, 3, high width in ticks that encodes stop.
- W_DRIVE, 4, high width in ticks that encodes drive.
- TIMEOUT, 80, ticks without a rising edge, or ticks continuously high, before the link is declared lost.
- CW, 7, counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- clk_dec  in  1  decoder clock, same rate as the generator's `clk_dec`.
- rst  in  1  reset.
- pwm_in  in  1  asynchronous PWM input.
- drive  out  2  decoded command: 2'b10 drive, 2'b00 stop, 2'b01 back.
- valid  out  1  high while the last decoded frame was good and the link is alive.
- cmd_stb  out  1  one-cycle pulse when `drive` is (re)written from a good pulse.
- err_stb  out  1  one-cycle pulse on a width, period or timeout error.

Behaviour:
- Clocking and reset: one clock, `clk_dec`. Reset `rst` is synchronous and active-high.
- Reset values: drive=2'b00, valid=0, cmd_stb=0, err_stb=0, state=IDLE, all counters=0, synchronizer flops=0.
- Reset asserted mid-operation: all reset values apply at the next edge and any partial pulse is discarded.
- Input path:
  - `pwm_in` passes through a 2-FF synchronizer to give `pwm_s`.
  - Edge detect on `pwm_s` against a registered copy gives rise/fall, each a one-cycle pulse.
- Counters:
  - hcnt counts cycles with `pwm_s`=1. It loads 1 on rise and increments while high.
  - pcnt counts cycles since the last rise. It loads 1 on rise and increments otherwise.
  - Both saturate at TIMEOUT.
- State machine:
  - IDLE: no reference rise yet. On rise go to HIGH with the first_frame flag set.
  - HIGH: on fall, classify hcnt:
    - W_BACK gives 01, W_STOP gives 00, W_DRIVE gives 10. Register drive, set valid=1, pulse cmd_stb.
    - Any other width: pulse err_stb; drive and valid unchanged.
    - In both cases go to LOW.
  - LOW, on rise:
    - If first_frame=0 and pcnt != PERIOD: pulse err_stb and set valid=0.
    - Then clear first_frame and go to HIGH.
  - Timeout:
    - In HIGH or LOW, if pcnt reaches TIMEOUT with no rise, go to IDLE.
    - On entering IDLE: valid=0, drive=2'b00 (failsafe stop), one err_stb pulse.
    - This also catches `pwm_in` stuck high.
- Latency: a `pwm_in` falling edge, first sampled low at edge k, updates drive/cmd_stb at edge k+3 (2 synchronizer stages plus 1 output register).
- Simultaneous events: a rise in the same cycle pcnt reaches TIMEOUT counts as a rise; no timeout occurs.
- After a period error, the next good fall restores valid=1.
- cmd_stb and err_stb are never high in the same cycle.
- Widths: all comparisons are unsigned on CW bits, and the counters never wrap.

Decomposition:
- Shared package `pwm_pkg`:
  - Drive codes DRIVE=2'b10, STOP=2'b00, BACK=2'b01, shared with the generator.
  - PERIOD and W_* defaults.
  - State enum IDLE/HIGH/LOW.
- One sub-module, `pwm_sync_edge`: 2-FF synchronizer plus registered edge detect, with outputs `pwm_s`, rise and fall. It is reusable for other asynchronous inputs.

Test Plan:
- Reset, then continuous 40-tick frames, 4 ticks high:
  - drive=2'b10 and valid=1 at edge k+3 after the first fall.
  - cmd_stb pulses once per frame; err_stb stays 0.
- Switch the frame width to 2 ticks, then 3 ticks: drive becomes 2'b01, then 2'b00, each on the first fall of the new width, with one cmd_stb per frame.
- Insert one 5-tick-high frame while decoding drive: one err_stb; drive stays 2'b10 and valid stays 1. The next good frame gives cmd_stb.
- After locking, shorten one frame to 38 ticks: err_stb and valid=0 at the following rise. valid returns to 1 at the next good fall.
- Hold `pwm_in` low for 80+ ticks, and separately hold it high for 80+ ticks:
  - Each case gives exactly one err_stb, then valid=0, drive=2'b00, state IDLE.
  - The first frame after recovery is decoded without a period check.
- Assert `rst` for 1 cycle during a high pulse: all outputs take reset values at the next edge. The partial pulse gives no cmd_stb; the next full frame decodes normally.
